mem_arbiter: RTL

Arbitrates the single unified memory bus between the datapath's instruction-fetch port and data port. Latches the winning request, drives the bus until the memory acknowledges, then returns the ack and read data to the owner. Supports a bus lock so RV32A read-modify-write sequences (AMO, LR/SC) complete without an intervening fetch. Sits between the datapath and the memory model/controller at system level.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the instruction-fetch port and the data port.
// The data port has priority. d_lock keeps the bus for the next data access, so that
// AMO and LR/SC pairs complete without a fetch in between.
// Optional build macro ARB_STARVE_GUARD_EN: after MAX_STARVE consecutive data grants
// while a fetch is waiting, the next arbitration from idle goes to the fetch port.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                if_ren,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  // data port
  input  logic                d_ren,
  input  logic                d_wen,
  input  logic                d_lock,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_strb,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  // memory bus
  output logic                bus_ren,
  output logic                bus_wen,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_strb,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StIfBusy, StDBusy, StDHold} state_e;

  state_e              state_q;
  logic                ren_q;
  logic                wen_q;
  logic                lock_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;

  logic d_req;
  logic grant_d;
  logic grant_if;
  logic done;
  logic force_if;

  assign d_req = d_ren | d_wen;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(MAX_STARVE + 1);

  logic [CNT_W-1:0] starve_q;

  // A waiting fetch wins once the data port has taken MAX_STARVE grants in a row.
  assign force_if = if_ren && (starve_q == CNT_W'(MAX_STARVE));

  // Count data grants from idle that made a fetch wait; any fetch grant clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (grant_if) begin
      starve_q <= '0;
    end else if (grant_d && (state_q == StIdle) && if_ren &&
                 (starve_q != CNT_W'(MAX_STARVE))) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  // Strict data priority. MAX_STARVE is only referenced so that it is not reported as unused.
  logic unused_max_starve;
  assign unused_max_starve = ^MAX_STARVE;
  assign force_if          = 1'b0;
`endif

  // Arbitration decision and completion detection for the current state.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (d_req && !force_if) begin
          grant_d = 1'b1;
        end else if (if_ren) begin
          grant_if = 1'b1;
        end
      end
      StDHold:  grant_d = d_req;
      default:  ;
    endcase
    done = bus_ready && ((state_q == StIfBusy) || (state_q == StDBusy));
  end

  // Main FSM. The bus drive is registered at grant and cleared on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      lock_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (grant_d) begin
      // When d_ren and d_wen are both high, the access is a write.
      state_q <= StDBusy;
      ren_q   <= ~d_wen;
      wen_q   <= d_wen;
      lock_q  <= d_lock;
      addr_q  <= d_addr;
      wdata_q <= d_wen ? d_wdata : '0;
      strb_q  <= d_wen ? d_strb : '1;
    end else if (grant_if) begin
      state_q <= StIfBusy;
      ren_q   <= 1'b1;
      wen_q   <= 1'b0;
      lock_q  <= 1'b0;
      addr_q  <= if_addr;
      wdata_q <= '0;
      strb_q  <= '1;
    end else if (done) begin
      state_q <= ((state_q == StDBusy) && lock_q) ? StDHold : StIdle;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if ((state_q == StDHold) && !d_lock) begin
      state_q <= StIdle;
      lock_q  <= 1'b0;
    end
  end

  assign bus_ren   = ren_q;
  assign bus_wen   = wen_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_strb  = strb_q;

  // The ack goes to the owner in the same cycle that the memory completes.
  assign if_ack   = done && (state_q == StIfBusy);
  assign d_ack    = done && (state_q == StDBusy);
  assign if_rdata = if_ack ? bus_rdata : '0;
  assign d_rdata  = (d_ack && !wen_q) ? bus_rdata : '0;

endmodule
